// File: rtl/alu_share_arbiter.sv
// Round-robin share of one 64-bit ALU between two requesters, with a
// registered response and an architectural ZF/SF/OF condition-code register.
module alu_share_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req0_setcc,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [1:0]  req1_op,
  input  logic        req1_setcc,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [63:0] resp_data,
  output logic        resp_zf,
  output logic        resp_sf,
  output logic        resp_of,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_prio, r_owner, r_setcc;
  logic [63:0] r_a, r_b;
  logic [1:0]  r_op;

  logic        w_grant0, w_grant1, w_accept, w_resp_hs;
  logic [63:0] w_o;
  logic        w_of;

  // prio only breaks ties; a lone valid requester always wins
  assign w_grant0 = req0_valid && (!req1_valid || !r_prio);
  assign w_grant1 = req1_valid && (!req0_valid ||  r_prio);
  assign w_accept  = (r_state == S_IDLE) && (w_grant0 || w_grant1);
  assign w_resp_hs = (r_state == S_RESP) && (r_owner ? resp1_ready : resp0_ready);

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready = rst_n && w_grant0;
        req1_ready = rst_n && w_grant1;
        if (w_accept) w_state_nxt = S_EXEC;
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        resp0_valid = rst_n && !r_owner;
        resp1_valid = rst_n &&  r_owner;
        if (w_resp_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_o  = '0;
    w_of = 1'b0;
    case (r_op)
      2'b00: begin
        w_o  = r_a + r_b;
        w_of = (r_a[63] == r_b[63]) && (w_o[63] != r_a[63]);
      end
      2'b01: begin
        w_o  = r_a - r_b;
        w_of = (r_a[63] != r_b[63]) && (w_o[63] != r_a[63]);
      end
      2'b10:   w_o = r_a & r_b;
      default: w_o = r_a ^ r_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_prio    <= 1'b0;
      r_owner   <= 1'b0;
      r_setcc   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      resp_data <= '0;
      resp_zf   <= 1'b0;
      resp_sf   <= 1'b0;
      resp_of   <= 1'b0;
      cc_zf     <= 1'b1;
      cc_sf     <= 1'b0;
      cc_of     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner <= w_grant1;
        r_a     <= w_grant1 ? req1_a     : req0_a;
        r_b     <= w_grant1 ? req1_b     : req0_b;
        r_op    <= w_grant1 ? req1_op    : req0_op;
        r_setcc <= w_grant1 ? req1_setcc : req0_setcc;
      end
      if (r_state == S_EXEC) begin
        resp_data <= w_o;
        resp_zf   <= (w_o == '0);
        resp_sf   <= w_o[63];
        resp_of   <= w_of;
        if (r_setcc) begin
          cc_zf <= (w_o == '0);
          cc_sf <= w_o[63];
          cc_of <= w_of;
        end
      end
      if (w_resp_hs) r_prio <= ~r_owner;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a vector table of single operations
// plus hand-written contention, backpressure and reset sequences.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_setcc;
  logic        req1_valid, req1_ready, req1_setcc;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [63:0] resp_data;
  logic        resp_zf, resp_sf, resp_of, cc_zf, cc_sf, cc_of;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .req0_setcc(req0_setcc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .req1_setcc(req1_setcc),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_zf(resp_zf), .resp_sf(resp_sf), .resp_of(resp_of),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  typedef struct {
    int          port;
    logic [1:0]  op;
    logic [63:0] a, b;
    logic        setcc;
    logic [63:0] data;
    logic        zf, sf, of;
    logic        czf, csf, cof;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int port, input logic v, input logic [1:0] op,
                       input logic [63:0] a, input logic [63:0] b, input logic setcc);
    if (port == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_setcc = setcc;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_setcc = setcc;
    end
  endtask

  // Called just after a negedge; waits (bounded) for ready on the given port.
  task automatic wait_ready(input int port, input string name);
    int n = 0;
    while (!((port == 0) ? req0_ready : req1_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk(name, (n < 10), 1);
  endtask

  // Called at the negedge in RESP: checks owner valid and result, then handshakes.
  task automatic check_resp(input int port, input string name, input logic [63:0] data);
    chk({name, "_vown"}, (port == 0) ? resp0_valid : resp1_valid, 1);
    chk({name, "_voth"}, (port == 0) ? resp1_valid : resp0_valid, 0);
    chk({name, "_data"}, resp_data, data);
    if (port == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    @(posedge clk); #1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  task automatic do_op(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(v.port, 1'b1, v.op, v.a, v.b, v.setcc);
    #1;
    wait_ready(v.port, {nm, "_rdy"});
    chk({nm, "_rdy_oth"}, (v.port == 0) ? req1_ready : req0_ready, 0);
    @(posedge clk); #1;
    drive(v.port, 1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    chk({nm, "_exec_v"}, {resp0_valid, resp1_valid}, 2'b00);
    @(negedge clk);
    chk({nm, "_flags"}, {resp_zf, resp_sf, resp_of}, {v.zf, v.sf, v.of});
    chk({nm, "_cc"}, {cc_zf, cc_sf, cc_of}, {v.czf, v.csf, v.cof});
    check_resp(v.port, nm, v.data);
  endtask

  initial begin
    vecs[0] = '{0, 2'b00, 64'd5, 64'd7, 1'b1, 64'd12, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 0, 0, 1};
    vecs[2] = '{0, 2'b11, 64'h1234, 64'h1234, 1'b0, 64'd0, 1, 0, 0, 0, 0, 1};
    vecs[3] = '{1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1,
                64'h8000_0000_0000_0000, 0, 1, 0, 0, 1, 0};
    vecs[4] = '{0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd0, 1, 0, 0, 1, 0, 0};
    vecs[5] = '{1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                64'h8000_0000_0000_0000, 0, 1, 1, 1, 0, 0};
    vecs[6] = '{0, 2'b01, 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 0, 1, 0};

    rst_n = 1'b1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    drive(0, 1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
    drive(1, 1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
    #2 rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
    chk("rst_rvalid", {resp0_valid, resp1_valid}, 2'b00);
    chk("rst_data", resp_data, 0);
    chk("rst_rflags", {resp_zf, resp_sf, resp_of}, 3'b000);
    chk("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Contention: both valid continuously, responses always accepted.
    drive(0, 1'b1, 2'b00, 64'd1, 64'd1, 1'b0);
    drive(1, 1'b1, 2'b01, 64'd10, 64'd3, 1'b0);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int exp_port, n;
      exp_port = k % 2;
      n = 0;
      #1;
      while (!(req0_ready || req1_ready) && n < 10) begin
        @(negedge clk); #1; n++;
      end
      chk($sformatf("cont%0d_wait", k), (n < 10), 1);
      chk($sformatf("cont%0d_grant", k), {req1_ready, req0_ready},
          (exp_port == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      chk($sformatf("cont%0d_exec_v", k), {resp1_valid, resp0_valid}, 2'b00);
      @(negedge clk);
      chk($sformatf("cont%0d_resp_v", k), {resp1_valid, resp0_valid},
          (exp_port == 0) ? 2'b01 : 2'b10);
      chk($sformatf("cont%0d_data", k), resp_data, (exp_port == 0) ? 64'd2 : 64'd7);
      if (k == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    for (int i = 0; i < 7; i++) do_op(vecs[i], i);

    // Backpressure: port 0 response stalled while both ports request.
    @(negedge clk);
    drive(0, 1'b1, 2'b00, 64'd100, 64'd23, 1'b0);
    #1;
    wait_ready(0, "bp_rdy0");
    @(posedge clk); #1;
    drive(0, 1'b1, 2'b11, 64'hAA, 64'h55, 1'b0);
    drive(1, 1'b1, 2'b10, 64'hF0F0, 64'hFF00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_v0", c), resp0_valid, 1);
      chk($sformatf("bp%0d_data", c), resp_data, 64'd123);
      chk($sformatf("bp%0d_rdy", c), {req0_ready, req1_ready}, 2'b00);
      @(negedge clk);
    end
    check_resp(0, "bp_r0", 64'd123);
    @(negedge clk);
    chk("bp_grant1", {req1_ready, req0_ready}, 2'b10);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check_resp(1, "bp_r1", 64'hF000);
    @(negedge clk);
    chk("bp_grant0", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check_resp(0, "bp_r0b", 64'hFF);

    // Reset during EXEC with prio pointing at port 1.
    @(negedge clk);
    drive(0, 1'b1, 2'b01, 64'd5, 64'd7, 1'b1);
    #1;
    wait_ready(0, "mr_rdy0");
    @(posedge clk); #1;
    drive(1, 1'b1, 2'b00, 64'd2, 64'd2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_rvalid", {resp0_valid, resp1_valid}, 2'b00);
    chk("mr_rdy", {req0_ready, req1_ready}, 2'b00);
    chk("mr_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    chk("mr_data", resp_data, 0);
    @(negedge clk);
    chk("mr_rvalid2", {resp0_valid, resp1_valid}, 2'b00);
    rst_n = 1'b1;
    #1;
    chk("mr_grant0", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("mr_cc_after", {cc_zf, cc_sf, cc_of}, 3'b010);
    check_resp(0, "mr_r0", 64'hFFFF_FFFF_FFFF_FFFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
